// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory port arbiter.
//   src_e       - requester identity recorded per in-flight bus transaction
//   tag_entry_t - tag FIFO entry: source plus kill flag for flushed fetches
package mem_arb_pkg;

  typedef enum logic {
    SRC_IFU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  typedef struct packed {
    src_e src;
    logic kill;
  } tag_entry_t;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// mem_arb_tag_fifo: DEPTH-deep FIFO of response tags, one per accepted bus request.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i/push_entry_i push a tag (ignored when full)
//   pop_i              pop the head (ignored when empty)
//   kill_ifu_i         mark every stored IFU tag as killed (visible next cycle)
//   head_o             current head entry
//   full_o, empty_o    occupancy flags
//   count_o            number of stored entries
module mem_arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  tag_entry_t               push_entry_i,
  input  logic                     pop_i,
  input  logic                     kill_ifu_i,
  output tag_entry_t               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  tag_entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0]     wptr_q, rptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 push_en, pop_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      // Killing stale slots is harmless; the push below overrides its own slot
      // so a tag accepted during the flush cycle survives.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill_ifu_i && mem_q[i].src == SRC_IFU) mem_q[i].kill <= 1'b1;
      end
      if (push_en) begin
        mem_q[wptr_q] <= push_entry_i;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (pop_en) rptr_q <= rptr_q + PTR_W'(1);
      if (push_en && !pop_en)      count_q <= count_q + CNT_W'(1);
      else if (pop_en && !push_en) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory bus between IFU fetch and LSU.
// Default: fixed LSU priority with an IFU starvation guard (STARVE_MAX).
// MEM_ARB_RR_EN defined: round-robin between sources, starve guard removed.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   ifu_req_*                  fetch request handshake + address
//   ifu_flush_i                kill all in-flight fetch responses
//   ifu_rsp_valid_o/data_o     fetch response (no back-pressure)
//   lsu_req_*                  load/store request handshake + payload
//   lsu_rsp_valid_o/data_o     load data / store ack (no back-pressure)
//   bus_req_*                  downstream request handshake + payload
//   bus_rsp_valid_i/data_i     downstream in-order responses
//   busy_o                     transactions outstanding
//   proto_err_o                sticky: response arrived with nothing outstanding
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned STARVE_MAX  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ifu_req_valid_i,
  output logic        ifu_req_ready_o,
  input  logic [31:0] ifu_req_addr_i,
  input  logic        ifu_flush_i,
  output logic        ifu_rsp_valid_o,
  output logic [31:0] ifu_rsp_data_o,
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic [31:0] lsu_req_addr_i,
  input  logic [31:0] lsu_req_wdata_i,
  input  logic        lsu_req_wen_i,
  input  logic [3:0]  lsu_req_wstrb_i,
  output logic        lsu_rsp_valid_o,
  output logic [31:0] lsu_rsp_data_o,
  output logic        bus_req_valid_o,
  input  logic        bus_req_ready_i,
  output logic [31:0] bus_req_addr_o,
  output logic [31:0] bus_req_wdata_o,
  output logic        bus_req_wen_o,
  output logic [3:0]  bus_req_wstrb_o,
  input  logic        bus_rsp_valid_i,
  input  logic [31:0] bus_rsp_data_i,
  output logic        busy_o,
  output logic        proto_err_o
);

  logic       hold_q, hold_d;
  src_e       hold_src_q, hold_src_d;
  logic       proto_err_q, proto_err_d;
  src_e       win_src;
  logic       win_valid, accept, pop;
  logic       fifo_full, fifo_empty;
  tag_entry_t head;
  logic [$clog2(OUTSTANDING):0] fifo_count;

`ifdef MEM_ARB_RR_EN
  src_e last_src_q, last_src_d;
`else
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starve_q, starve_d;
`endif

  // Winner selection; a stalled request keeps its grant until accepted.
  always_comb begin
    win_src = SRC_IFU;
    if (hold_q) win_src = hold_src_q;
`ifdef MEM_ARB_RR_EN
    else if (lsu_req_valid_i && ifu_req_valid_i)
      win_src = (last_src_q == SRC_LSU) ? SRC_IFU : SRC_LSU;
`else
    else if (starve_q == STARVE_W'(STARVE_MAX) && ifu_req_valid_i) win_src = SRC_IFU;
`endif
    else if (lsu_req_valid_i) win_src = SRC_LSU;
  end

  assign win_valid       = (win_src == SRC_LSU) ? lsu_req_valid_i : ifu_req_valid_i;
  assign bus_req_valid_o = win_valid & ~fifo_full;
  assign accept          = bus_req_valid_o & bus_req_ready_i;
  assign lsu_req_ready_o = (win_src == SRC_LSU) & bus_req_ready_i & ~fifo_full;
  assign ifu_req_ready_o = (win_src == SRC_IFU) & bus_req_ready_i & ~fifo_full;

  always_comb begin
    bus_req_addr_o  = ifu_req_addr_i;
    bus_req_wdata_o = '0;
    bus_req_wen_o   = 1'b0;
    bus_req_wstrb_o = '0;
    if (win_src == SRC_LSU) begin
      bus_req_addr_o  = lsu_req_addr_i;
      bus_req_wdata_o = lsu_req_wdata_i;
      bus_req_wen_o   = lsu_req_wen_i;
      bus_req_wstrb_o = lsu_req_wstrb_i;
    end
  end

  // Hold tracks a presented-but-stalled request; it drops on accept.
  always_comb begin
    hold_d     = bus_req_valid_o & ~bus_req_ready_i;
    hold_src_d = win_src;
  end

`ifdef MEM_ARB_RR_EN
  always_comb begin
    last_src_d = last_src_q;
    if (accept) last_src_d = win_src;
  end
`else
  always_comb begin
    starve_d = starve_q;
    if (!ifu_req_valid_i) starve_d = '0;
    else if (accept) begin
      if (win_src == SRC_IFU) starve_d = '0;
      else if (starve_q != STARVE_W'(STARVE_MAX)) starve_d = starve_q + STARVE_W'(1);
    end
  end
`endif

  // Response routing follows the FIFO head; flush in the same cycle also kills.
  assign pop             = bus_rsp_valid_i & ~fifo_empty;
  assign ifu_rsp_valid_o = pop & (head.src == SRC_IFU) & ~head.kill & ~ifu_flush_i;
  assign lsu_rsp_valid_o = pop & (head.src == SRC_LSU);
  assign ifu_rsp_data_o  = bus_rsp_data_i;
  assign lsu_rsp_data_o  = bus_rsp_data_i;
  assign proto_err_d     = proto_err_q | (bus_rsp_valid_i & fifo_empty);
  assign proto_err_o     = proto_err_q;
  assign busy_o          = (fifo_count != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q      <= 1'b0;
      hold_src_q  <= SRC_IFU;
      proto_err_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_src_q  <= SRC_IFU;
`else
      starve_q    <= '0;
`endif
    end else begin
      hold_q      <= hold_d;
      hold_src_q  <= hold_src_d;
      proto_err_q <= proto_err_d;
`ifdef MEM_ARB_RR_EN
      last_src_q  <= last_src_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  mem_arb_tag_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (accept),
    .push_entry_i ('{src: win_src, kill: 1'b0}),
    .pop_i        (pop),
    .kill_ifu_i   (ifu_flush_i),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

endmodule
